// File: rtl/cpu_run_controller.sv
// ---------------------------------------------------------------------------
// cpu_run_controller: halted / free-run / single-step sequencer driving the CPU clock enable.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cpu_run_controller #(
  parameter int ADDR_WIDTH = 16,
  parameter int STEP_BURST = 1,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run_btn,
  input  logic                  step_btn,
  input  logic                  halt_btn,
  input  logic                  speed_sel,
  input  logic                  tick_in,
  output logic                  tick_enable,
  input  logic                  cpu_halt_req,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  bp_enable,
  input  logic [ADDR_WIDTH-1:0] bp_addr,
  output logic                  cpu_en,
  output logic [1:0]            state,
  output logic [CNT_WIDTH-1:0]  cycle_count
);

  localparam int SW = (STEP_BURST < 2) ? 1 : $clog2(STEP_BURST + 1);

  typedef enum logic [1:0] {
    HALTED = 2'b00,
    RUN    = 2'b01,
    STEP   = 2'b10
  } state_t;

  state_t        cur;
  logic [SW-1:0] step_cnt;
  logic          resume;
  logic          run_prev;
  logic          step_prev;

  logic run_rise;
  logic step_rise;
  logic stop_req;
  logic paced_go;
  logic bp_hit;

  assign run_rise  = run_btn & ~run_prev;
  assign step_rise = step_btn & ~step_prev;
  assign stop_req  = halt_btn | cpu_halt_req;
  assign paced_go  = ~speed_sel | tick_in;
  // The resume flag lets execution leave a breakpoint address it stopped on.
  assign bp_hit    = bp_enable & (pc == bp_addr) & ~resume;
  assign state     = cur;

  always_ff @(posedge clk) begin
    if (reset) begin
      cur         <= HALTED;
      cpu_en      <= 1'b0;
      tick_enable <= 1'b0;
      cycle_count <= '0;
      step_cnt    <= '0;
      resume      <= 1'b0;
      run_prev    <= 1'b0;
      step_prev   <= 1'b0;
    end else begin
      run_prev    <= run_btn;
      step_prev   <= step_btn;
      cpu_en      <= 1'b0;
      tick_enable <= 1'b0;
      unique case (cur)
        HALTED: begin
          if (!stop_req) begin
            if (run_rise) begin
              cur         <= RUN;
              resume      <= 1'b1;
              tick_enable <= speed_sel;
            end else if (step_rise) begin
              cur      <= STEP;
              step_cnt <= SW'(STEP_BURST);
              resume   <= 1'b1;
            end
          end
        end
        RUN: begin
          if (stop_req || (paced_go && bp_hit)) begin
            cur <= HALTED;
          end else begin
            tick_enable <= speed_sel;
            if (paced_go) begin
              cpu_en      <= 1'b1;
              resume      <= 1'b0;
              cycle_count <= cycle_count + CNT_WIDTH'(1);
            end
          end
        end
        STEP: begin
          if (stop_req) begin
            cur      <= HALTED;
            step_cnt <= '0;
          end else begin
            // Final strobe is issued on the same edge that returns to HALTED.
            cpu_en      <= 1'b1;
            resume      <= 1'b0;
            cycle_count <= cycle_count + CNT_WIDTH'(1);
            step_cnt    <= step_cnt - SW'(1);
            if (step_cnt <= SW'(1)) cur <= HALTED;
          end
        end
        default: cur <= HALTED;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cpu_run_controller.sv
// ---------------------------------------------------------------------------
// tb_cpu_run_controller: directed scenarios plus random stimulus against a scoreboarded reference model.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cpu_run_controller;

  localparam int AW    = 16;
  localparam int BURST = 3;
  localparam int CW    = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          run_btn = 1'b0;
  logic          step_btn = 1'b0;
  logic          halt_btn = 1'b0;
  logic          speed_sel = 1'b0;
  logic          tick_in = 1'b0;
  logic          tick_enable;
  logic          cpu_halt_req = 1'b0;
  logic [AW-1:0] pc = '0;
  logic          bp_enable = 1'b0;
  logic [AW-1:0] bp_addr = 16'h0010;
  logic          cpu_en;
  logic [1:0]    state;
  logic [CW-1:0] cycle_count;

  always #5 clk = ~clk;

  cpu_run_controller #(
    .ADDR_WIDTH(AW),
    .STEP_BURST(BURST),
    .CNT_WIDTH (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .run_btn     (run_btn),
    .step_btn    (step_btn),
    .halt_btn    (halt_btn),
    .speed_sel   (speed_sel),
    .tick_in     (tick_in),
    .tick_enable (tick_enable),
    .cpu_halt_req(cpu_halt_req),
    .pc          (pc),
    .bp_enable   (bp_enable),
    .bp_addr     (bp_addr),
    .cpu_en      (cpu_en),
    .state       (state),
    .cycle_count (cycle_count)
  );

  typedef struct packed {
    logic [1:0]    st;
    logic          en;
    logic          tke;
    logic [CW-1:0] cnt;
  } obs_t;

  obs_t exp_q[$];
  obs_t mon_exp;
  obs_t mon_act;
  int   checks = 0;
  int   passed = 0;

  // Reference model: mode 0 halted, 1 running, 2 stepping; strobes is a plain running total.
  int m_mode      = 0;
  int m_left      = 0;
  int m_strobes   = 0;
  bit m_resume    = 0;
  bit m_run_prev  = 0;
  bit m_step_prev = 0;

  bit pc_follow   = 0;
  int pc_base     = 0;
  int strobe_base = 0;

  task automatic model_edge();
    bit   rr, sr, stop, fire, go;
    int   nxt;
    obs_t e;
    rr   = run_btn && !m_run_prev;
    sr   = step_btn && !m_step_prev;
    stop = halt_btn || cpu_halt_req;
    go   = !speed_sel || tick_in;
    fire = 0;
    nxt  = m_mode;
    if (reset) begin
      nxt = 0; m_left = 0; m_strobes = 0; m_resume = 0;
      m_run_prev = 0; m_step_prev = 0;
    end else begin
      if (m_mode == 0) begin
        if (!stop && rr) begin
          nxt = 1; m_resume = 1;
        end else if (!stop && sr) begin
          nxt = 2; m_left = BURST; m_resume = 1;
        end
      end else if (m_mode == 1) begin
        if (stop) nxt = 0;
        else if (go) begin
          if (bp_enable && pc == bp_addr && !m_resume) nxt = 0;
          else fire = 1;
        end
      end else begin
        if (stop) begin
          nxt = 0; m_left = 0;
        end else begin
          fire = 1;
          m_left = m_left - 1;
          if (m_left == 0) nxt = 0;
        end
      end
      if (fire) begin
        m_resume  = 0;
        m_strobes = m_strobes + 1;
      end
      m_run_prev  = run_btn;
      m_step_prev = step_btn;
    end
    m_mode = nxt;
    e.st   = 2'(nxt);
    e.en   = fire;
    e.tke  = (nxt == 1) && speed_sel && !reset;
    e.cnt  = m_strobes[CW-1:0];
    exp_q.push_back(e);
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      if (pc_follow) pc = AW'(pc_base + m_strobes - strobe_base);
      model_edge();
      @(posedge clk);
      @(negedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = {state, cpu_en, tick_enable, cycle_count};
      checks++;
      if (mon_act === mon_exp) passed++;
      else $display("FAIL outputs @%0t: got state=%b cpu_en=%b tick_enable=%b cycle_count=%0d, expected state=%b cpu_en=%b tick_enable=%b cycle_count=%0d",
                    $time, mon_act.st, mon_act.en, mon_act.tke, mon_act.cnt,
                    mon_exp.st, mon_exp.en, mon_exp.tke, mon_exp.cnt);
    end
  end

  initial begin
    cyc(2);
    reset = 1'b0;
    cyc(2);

    // Fast run, then halt button
    run_btn = 1'b1; cyc(11);
    halt_btn = 1'b1; cyc(2);
    halt_btn = 1'b0; run_btn = 1'b0; cyc(2);

    // Reset in the middle of a fast run
    run_btn = 1'b1; cyc(5);
    reset = 1'b1; cyc(1);
    reset = 1'b0; run_btn = 1'b0; cyc(2);

    // Slow run paced by tick_in every 5 cycles
    speed_sel = 1'b1; run_btn = 1'b1;
    for (int i = 0; i < 21; i++) begin
      tick_in = (i % 5 == 4);
      cyc(1);
    end
    tick_in = 1'b0; halt_btn = 1'b1; cyc(1);
    halt_btn = 1'b0; run_btn = 1'b0; speed_sel = 1'b0; cyc(2);

    // Breakpoint at 0x0010 with pc tracking the strobes, then resume past it
    bp_enable = 1'b1; bp_addr = 16'h0010;
    pc_follow = 1; pc_base = 16'h000C; strobe_base = m_strobes;
    run_btn = 1'b1; cyc(10);
    run_btn = 1'b0; cyc(2);
    run_btn = 1'b1; cyc(6);
    halt_btn = 1'b1; cyc(1);
    halt_btn = 1'b0; run_btn = 1'b0; pc_follow = 0; bp_enable = 1'b0; cyc(2);

    // Step burst, then simultaneous run and step
    step_btn = 1'b1; cyc(6);
    step_btn = 1'b0; cyc(1);
    run_btn = 1'b1; step_btn = 1'b1; cyc(3);
    halt_btn = 1'b1; cyc(1);
    halt_btn = 1'b0; run_btn = 1'b0; step_btn = 1'b0; cyc(2);

    // Step aborted by the halt button
    step_btn = 1'b1; cyc(2);
    halt_btn = 1'b1; cyc(1);
    halt_btn = 1'b0; step_btn = 1'b0; cyc(3);

    // CPU HLT during run; run request while HLT is held is ignored
    run_btn = 1'b1; cyc(3);
    cpu_halt_req = 1'b1; cyc(2);
    run_btn = 1'b0; cyc(1);
    run_btn = 1'b1; cyc(3);
    cpu_halt_req = 1'b0; run_btn = 1'b0; cyc(2);

    // Random traffic with breakpoints near pc
    bp_addr = 16'h0010;
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 299) == 0);
      halt_btn     = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 59) == 0) cpu_halt_req = ~cpu_halt_req;
      if ($urandom_range(0, 7) == 0) run_btn = ~run_btn;
      if ($urandom_range(0, 7) == 0) step_btn = ~step_btn;
      if ($urandom_range(0, 49) == 0) speed_sel = ~speed_sel;
      if ($urandom_range(0, 99) == 0) bp_enable = ~bp_enable;
      tick_in      = ($urandom_range(0, 3) == 0);
      pc           = AW'($urandom_range(16'h000E, 16'h0012));
      cyc(1);
    end

    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
- Sequences execution of the 16-bit CPU by generating a one-cycle advance strobe, cpu_en, consumed by the CPU as its clock enable.
- Supports halted, free-run and single-step operation.
- Free-run operates at full clock rate or paced by the 1 Hz tick from the pulse generator; this block owns that generator's enable.
- Adds a PC breakpoint and honours the CPU's HLT request.

Parameters:
ADDR_WIDTH, 16, width of pc and bp_addr
STEP_BURST, 1, number of cpu_en strobes issued per step request (>=1)
CNT_WIDTH, 32, width of cycle_count

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
run_btn  input  1  debounced run request; rising edge acts
step_btn  input  1  debounced single-step request; rising edge acts
halt_btn  input  1  debounced halt request; level acts
speed_sel  input  1  0 = full rate, 1 = paced by tick_in
tick_in  input  1  one-cycle pulse from pulse generator
tick_enable  output  1  enable for pulse generator
cpu_halt_req  input  1  CPU executed HLT (level)
pc  input  ADDR_WIDTH  current CPU program counter
bp_enable  input  1  breakpoint armed
bp_addr  input  ADDR_WIDTH  breakpoint address
cpu_en  output  1  one-cycle CPU advance strobe (registered)
state  output  2  00 HALTED, 01 RUN, 10 STEP
cycle_count  output  CNT_WIDTH  number of cpu_en strobes issued

Behaviour:
- Reset values (reset high at an edge): state=HALTED, cpu_en=0, tick_enable=0, cycle_count=0, step counter=0, resume flag=0, edge detectors' previous-value regs=0. Reset has highest priority in any state, including mid-step.
- Edge detect: run_rise = run_btn & ~run_prev; step_rise likewise. Prev regs update every cycle.
- Event priority, highest first: reset > halt_btn > cpu_halt_req > breakpoint > run_rise > step_rise.
- HALTED:
  - run_rise with cpu_halt_req=0 -> RUN; resume flag set.
  - Otherwise step_rise with cpu_halt_req=0 -> STEP; step counter=STEP_BURST; resume flag set.
  - Simultaneous run_rise and step_rise -> RUN.
- RUN:
  - halt_btn or cpu_halt_req -> HALTED; no further cpu_en is issued from that edge.
  - run_rise and step_rise are ignored.
  - Fast (speed_sel=0): cpu_en<=1 every cycle in RUN.
  - Slow (speed_sel=1): cpu_en<=1 in the cycle after tick_in=1 is sampled in RUN.
  - speed_sel changes take effect at the next edge.
- Breakpoint:
  - Evaluated at each edge where RUN would set cpu_en<=1.
  - If bp_enable=1, pc==bp_addr and the resume flag=0: cpu_en<=0 and state -> HALTED.
  - The resume flag is cleared on the first cpu_en after leaving HALTED, so resuming from a breakpoint address executes that instruction.
  - In STEP, the breakpoint is ignored.
- STEP:
  - cpu_en<=1 on consecutive cycles, ignoring speed_sel, while step counter>0; counter decrements per strobe.
  - Counter reaching 0 -> HALTED.
  - halt_btn or cpu_halt_req aborts -> HALTED; the counter is cleared.
- tick_enable is registered: 1 when next state is RUN and speed_sel=1, else 0. The pulse generator therefore restarts its count on every entry to slow run.
- Latency: run_rise sampled at edge T -> state=RUN after T. In fast mode, cpu_en=1 after T+1.
- cycle_count increments on every edge where cpu_en<=1 is registered. It wraps from all-ones to 0 and is cleared only by reset.
- cpu_en is never asserted while state=HALTED is presented, except the final STEP strobe issued in the transition cycle.

Test Plan:
- Reset mid-RUN with speed_sel=0 -> next cycle state=00, cpu_en=0, tick_enable=0, cycle_count=0.
- HALTED, run_btn 0->1, speed_sel=0, bp_enable=0; 10 cycles later assert halt_btn -> cpu_en high 2 cycles after the edge, low 1 cycle after halt_btn; cycle_count reflects exactly the strobes seen.
- RUN, speed_sel=1, tick_in pulsed every 5 cycles, 4 ticks -> tick_enable=1, cpu_en is a single-cycle pulse one cycle after each tick, cycle_count=4.
- bp_enable=1, bp_addr=0x0010, pc follows cycle_count from 0x000C -> halts with last strobe at pc=0x000F; second run_rise at pc=0x0010 -> strobe issued, run continues past 0x0011.
- STEP_BURST=3, step_rise in HALTED -> exactly 3 consecutive cpu_en, then state=00; step_rise and run_rise together -> state=01.
- cpu_halt_req=1 during RUN -> HALTED next edge; run_rise while cpu_halt_req=1 ignored, state stays 00.
